// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: PC register, IF/ID pipeline register and a 1-entry skid buffer.
// Optional halt detection on opcode 4'b1111 is enabled by defining FETCH_HALT_DETECT_EN.
module pc_fetch_ctrl #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_pc,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus,
  output logic        ifid_valid,
  output logic        halted
);

  typedef enum logic [1:0] {REQ, HOLD, HALT} state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] skid_instr, skid_instr_n;
  logic [15:0] skid_pc, skid_pc_n;
  logic [15:0] ifid_instr_n, ifid_pc_plus_n;
  logic        ifid_valid_n;
  logic [15:0] dlv_instr, dlv_pc, dlv_pc_plus;
  logic        halt_hit;

  // The instruction that would enter IF/ID this cycle comes from memory or the skid entry.
  assign dlv_instr   = (state == HOLD) ? skid_instr : imem_data;
  assign dlv_pc      = (state == HOLD) ? skid_pc    : pc;
  assign dlv_pc_plus = dlv_pc + 16'd1;

`ifdef FETCH_HALT_DETECT_EN
  assign halt_hit = (dlv_instr[15:12] == 4'b1111);
  assign halted   = (state == HALT);
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  always_comb begin
    state_n        = state;
    pc_n           = pc;
    skid_instr_n   = skid_instr;
    skid_pc_n      = skid_pc;
    ifid_instr_n   = ifid_instr;
    ifid_pc_plus_n = ifid_pc_plus;
    ifid_valid_n   = ifid_valid;
    if (br_taken) begin
      // Redirect wins over everything, including stall and any returning data.
      state_n      = REQ;
      pc_n         = br_pc;
      skid_instr_n = 16'h0000;
      skid_pc_n    = 16'h0000;
      ifid_instr_n = NOP_INSTR;
      ifid_valid_n = 1'b0;
    end else begin
      unique case (state)
        REQ: begin
          if (imem_rdy && !stall) begin
            ifid_instr_n   = dlv_instr;
            ifid_pc_plus_n = dlv_pc_plus;
            ifid_valid_n   = 1'b1;
            if (halt_hit) state_n = HALT;
            else          pc_n    = dlv_pc_plus;
          end else if (imem_rdy) begin
            skid_instr_n = imem_data;
            skid_pc_n    = pc;
            state_n      = HOLD;
          end else if (!stall) begin
            ifid_instr_n = NOP_INSTR;
            ifid_valid_n = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_instr_n   = dlv_instr;
            ifid_pc_plus_n = dlv_pc_plus;
            ifid_valid_n   = 1'b1;
            if (halt_hit) begin
              pc_n    = dlv_pc;
              state_n = HALT;
            end else begin
              pc_n    = dlv_pc_plus;
              state_n = REQ;
            end
          end
        end
        HALT: begin
          // Decode took the halt instruction; keep feeding bubbles so it is not re-issued.
          if (!stall) begin
            ifid_instr_n = NOP_INSTR;
            ifid_valid_n = 1'b0;
          end
        end
        default: state_n = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= REQ;
      pc           <= RESET_PC;
      skid_instr   <= 16'h0000;
      skid_pc      <= 16'h0000;
      ifid_instr   <= NOP_INSTR;
      ifid_pc_plus <= 16'h0000;
      ifid_valid   <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      skid_instr   <= skid_instr_n;
      skid_pc      <= skid_pc_n;
      ifid_instr   <= ifid_instr_n;
      ifid_pc_plus <= ifid_pc_plus_n;
      ifid_valid   <= ifid_valid_n;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed scoreboard bench for pc_fetch_ctrl: each stimulus step queues the expected
// post-edge outputs and a monitor compares them on the following falling edge.
module tb_pc_fetch_ctrl;
  localparam logic [15:0] NOP = 16'hE0E0;

  logic        clk = 1'b0;
  logic        rst, imem_rdy, stall, br_taken;
  logic [15:0] imem_data, br_pc;
  logic        imem_req, ifid_valid, halted;
  logic [15:0] imem_addr, ifid_instr, ifid_pc_plus;

  typedef struct {
    string       name;
    logic        req;
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pcp;
    logic        valid;
    logic        halt;
    logic        chk_instr;
    logic        chk_pcp;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_PC(16'h0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdy(imem_rdy), .imem_data(imem_data), .stall(stall),
    .br_taken(br_taken), .br_pc(br_pc), .ifid_instr(ifid_instr),
    .ifid_pc_plus(ifid_pc_plus), .ifid_valid(ifid_valid), .halted(halted)
  );

  // Monitor: outputs are all state-derived, so compare on the falling edge.
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e  = q.pop_front();
        ok = (imem_req === e.req) && (imem_addr === e.addr) &&
             (ifid_valid === e.valid) && (halted === e.halt);
        if (e.chk_instr && ifid_instr !== e.instr) ok = 1'b0;
        if (e.chk_pcp && ifid_pc_plus !== e.pcp)   ok = 1'b0;
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL %s: got req=%b addr=%h instr=%h pcp=%h valid=%b halted=%b; expected req=%b addr=%h instr=%h pcp=%h valid=%b halted=%b",
                   e.name, imem_req, imem_addr, ifid_instr, ifid_pc_plus, ifid_valid, halted,
                   e.req, e.addr, e.instr, e.pcp, e.valid, e.halt);
        end
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic rdy, input logic [15:0] d,
                      input logic st, input logic br, input logic [15:0] bp,
                      input logic er, input logic [15:0] ea, input logic [15:0] ei,
                      input logic [15:0] ep, input logic ev, input logic eh,
                      input logic ci, input logic cp);
    exp_t e;
    rst = r; imem_rdy = rdy; imem_data = d; stall = st; br_taken = br; br_pc = bp;
    @(posedge clk);
    e.name = nm; e.req = er; e.addr = ea; e.instr = ei; e.pcp = ep;
    e.valid = ev; e.halt = eh; e.chk_instr = ci; e.chk_pcp = cp;
    q.push_back(e);
    #1;
  endtask

  initial begin
    int waited;
    rst = 1'b1; imem_rdy = 1'b0; imem_data = 16'h0; stall = 1'b0; br_taken = 1'b0; br_pc = 16'h0;
    //    name          rst rdy data      st br brpc      req addr      instr     pcp       v  h  ci cp
    step("reset",        1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, NOP,      16'h0000, 0, 0, 1, 1);
    step("fetch0",       0, 1, 16'h1111, 0, 0, 16'h0000, 1, 16'h0001, 16'h1111, 16'h0001, 1, 0, 1, 1);
    step("fetch1",       0, 1, 16'h2222, 0, 0, 16'h0000, 1, 16'h0002, 16'h2222, 16'h0002, 1, 0, 1, 1);
    step("bubble",       0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, NOP,      16'h0000, 0, 0, 1, 0);
    step("fetch2",       0, 1, 16'h3333, 0, 0, 16'h0000, 1, 16'h0003, 16'h3333, 16'h0003, 1, 0, 1, 1);
    step("fetch3",       0, 1, 16'h4444, 0, 0, 16'h0000, 1, 16'h0004, 16'h4444, 16'h0004, 1, 0, 1, 1);
    step("fetch4",       0, 1, 16'h5555, 0, 0, 16'h0000, 1, 16'h0005, 16'h5555, 16'h0005, 1, 0, 1, 1);
    step("wait_stall",   0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0005, 16'h5555, 16'h0005, 1, 0, 1, 1);
    step("skid_in",      0, 1, 16'hABCD, 1, 0, 16'h0000, 0, 16'h0005, 16'h5555, 16'h0005, 1, 0, 1, 1);
    step("hold",         0, 1, 16'h9999, 1, 0, 16'h0000, 0, 16'h0005, 16'h5555, 16'h0005, 1, 0, 1, 1);
    step("skid_out",     0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0006, 16'hABCD, 16'h0006, 1, 0, 1, 1);
    step("br_stall",     0, 1, 16'h7777, 1, 1, 16'h0040, 1, 16'h0040, NOP,      16'h0000, 0, 0, 1, 0);
    step("fetch_40",     0, 1, 16'h4040, 0, 0, 16'h0000, 1, 16'h0041, 16'h4040, 16'h0041, 1, 0, 1, 1);
    step("br_ffff",      0, 0, 16'h0000, 0, 1, 16'hFFFF, 1, 16'hFFFF, NOP,      16'h0000, 0, 0, 1, 0);
    step("wrap",         0, 1, 16'hFEED, 0, 0, 16'h0000, 1, 16'h0000, 16'hFEED, 16'h0000, 1, 0, 1, 1);
    step("fetch_0",      0, 1, 16'h0101, 0, 0, 16'h0000, 1, 16'h0001, 16'h0101, 16'h0001, 1, 0, 1, 1);
    step("skid_in2",     0, 1, 16'h1234, 1, 0, 16'h0000, 0, 16'h0001, 16'h0101, 16'h0001, 1, 0, 1, 1);
    step("rst_in_hold",  1, 1, 16'h5678, 1, 1, 16'h0055, 1, 16'h0000, NOP,      16'h0000, 0, 0, 1, 1);
    step("post_rst0",    0, 1, 16'h0A0A, 0, 0, 16'h0000, 1, 16'h0001, 16'h0A0A, 16'h0001, 1, 0, 1, 1);
    step("post_rst1",    0, 1, 16'h0B0B, 0, 0, 16'h0000, 1, 16'h0002, 16'h0B0B, 16'h0002, 1, 0, 1, 1);
    step("post_rst2",    0, 1, 16'h0C0C, 0, 0, 16'h0000, 1, 16'h0003, 16'h0C0C, 16'h0003, 1, 0, 1, 1);
`ifdef FETCH_HALT_DETECT_EN
    step("halt_hit",     0, 1, 16'hF000, 0, 0, 16'h0000, 0, 16'h0003, 16'hF000, 16'h0004, 1, 1, 1, 1);
    step("halt_stay",    0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0003, 16'hF000, 16'h0004, 1, 1, 1, 1);
    step("halt_bubble",  0, 1, 16'h1357, 0, 0, 16'h0000, 0, 16'h0003, NOP,      16'h0000, 0, 1, 1, 0);
`else
    step("f_opcode",     0, 1, 16'hF000, 0, 0, 16'h0000, 1, 16'h0004, 16'hF000, 16'h0004, 1, 0, 1, 1);
    step("f_stall",      0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0004, 16'hF000, 16'h0004, 1, 0, 1, 1);
`endif
    step("br_10",        0, 0, 16'h0000, 0, 1, 16'h0010, 1, 16'h0010, NOP,      16'h0000, 0, 0, 1, 0);
    step("fetch_10",     0, 1, 16'h2020, 0, 0, 16'h0000, 1, 16'h0011, 16'h2020, 16'h0011, 1, 0, 1, 1);
    step("skid_in3",     0, 1, 16'h3030, 1, 0, 16'h0000, 0, 16'h0011, 16'h2020, 16'h0011, 1, 0, 1, 1);
    step("br_in_hold",   0, 1, 16'h4141, 0, 1, 16'h0080, 1, 16'h0080, NOP,      16'h0000, 0, 0, 1, 0);
    step("skid_gone",    0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0080, NOP,      16'h0000, 0, 0, 1, 0);
    step("fetch_80",     0, 1, 16'h5050, 0, 0, 16'h0000, 1, 16'h0081, 16'h5050, 16'h0081, 1, 0, 1, 1);

    waited = 0;
    while (q.size() != 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, 16'h0000, instruction driven into IF/ID on bubble or flush.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port imem_req, output, 1, instruction-memory read request.
REQ-006 SHALL have port imem_addr, output, 16, word address of the requested instruction (equals pc).
REQ-007 SHALL have port imem_rdy, input, 1, memory returns imem_data this cycle.
REQ-008 SHALL have port imem_data, input, 16, fetched instruction.
REQ-009 SHALL have port stall, input, 1, decode cannot accept a new IF/ID entry.
REQ-010 SHALL have port br_taken, input, 1, downstream branch resolved taken this cycle.
REQ-011 SHALL have port br_pc, input, 16, branch target; valid only when br_taken=1.
REQ-012 SHALL have port ifid_instr, output, 16, registered instruction to decode.
REQ-013 SHALL have port ifid_pc_plus, output, 16, registered address of that instruction plus 1.
REQ-014 SHALL have port ifid_valid, output, 1, IF/ID entry holds a real instruction.
REQ-015 SHALL have port halted, output, 1, fetch stopped on a halt instruction.

Function
REQ-016 SHALL implement states REQ, HOLD, HALT.
REQ-017 SHALL, in REQ, drive imem_req=1 and imem_addr=pc, holding both stable until imem_rdy=1.
REQ-018 SHALL, in REQ with imem_rdy=1 and stall=0, load ifid_instr=imem_data, ifid_pc_plus=pc+1, ifid_valid=1, and set pc=pc+1 (mod 2^16, 16'hFFFF wraps to 16'h0000).
REQ-019 SHALL, in REQ with imem_rdy=1 and stall=1, capture imem_data and pc into a 1-entry skid buffer, leave IF/ID unchanged, and go to HOLD.
REQ-020 SHALL, in REQ with imem_rdy=0 and stall=0, load IF/ID with NOP_INSTR and ifid_valid=0; with stall=1, hold IF/ID.
REQ-021 SHALL, in HOLD, drive imem_req=0 and hold IF/ID while stall=1; on stall=0, move the skid entry to IF/ID (valid=1), set pc=buffered pc+1, and go to REQ.
REQ-022 SHALL give br_taken priority over every other event in every state: pc=br_pc, IF/ID flushed (NOP_INSTR, valid=0) regardless of stall, skid buffer discarded, next state REQ.
REQ-023 SHALL ignore imem_rdy/imem_data in any cycle where br_taken=1.
REQ-024 SHALL have fetch-to-IF/ID latency of 1 cycle after the imem_rdy cycle when stall=0.
REQ-025 SHALL never drop or duplicate an accepted instruction absent br_taken.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, set pc=RESET_PC, state=REQ, ifid_instr=NOP_INSTR, ifid_pc_plus=16'h0000, ifid_valid=0, halted=0, and clear the skid buffer; rst overrides br_taken and all in-flight fetches.
REQ-027 SHALL drive imem_req=1, imem_addr=RESET_PC in the first cycle after rst deasserts.

Configuration
REQ-028 SHALL, with FETCH_HALT_DETECT_EN defined, treat an instruction with opcode 4'b1111 delivered to IF/ID (REQ-018 or REQ-021) as halt: pc not incremented, state=HALT, halted=1, imem_req=0; remains until rst or br_taken (br_taken clears halted and redirects per REQ-022).
REQ-029 SHALL, without FETCH_HALT_DETECT_EN, pass opcode 4'b1111 as an ordinary instruction; HALT is unreachable and halted is tied to 0.

Verification
REQ-030 Reset then imem_rdy=1 every cycle, stall=0, data 16'h1111,16'h2222 -> imem_addr 0,1,2; IF/ID (16'h1111,pc_plus 1,valid) then (16'h2222,2).
REQ-031 imem_rdy=1 with stall=1 on data 16'hABCD at pc 5 -> HOLD, imem_req=0, IF/ID unchanged; stall=0 two cycles later -> IF/ID 16'hABCD, pc_plus 6, next imem_addr 6.
REQ-032 br_taken=1, br_pc=16'h0040 while stall=1 and imem_rdy=1 -> next cycle ifid_valid=0, ifid_instr=NOP_INSTR, imem_addr=16'h0040, returned data discarded.
REQ-033 pc=16'hFFFF fetch accepted -> ifid_pc_plus=16'h0000, next imem_addr=16'h0000.
REQ-034 FETCH_HALT_DETECT_EN defined, data 16'hF000 at pc 3 -> halted=1, imem_req=0, pc stays 3; later br_taken, br_pc=16'h0010 -> halted=0, imem_addr=16'h0010.
REQ-035 rst=1 asserted in HOLD with br_taken=1 -> next cycle all outputs at REQ-026 values, imem_addr=RESET_PC.
